fixed_to_fp: RTL and testbench

FIXED_TO_FP -- requirements
Module: fixed_to_fp

---
 rtl/fixed_to_fp_pkg.sv | 18 +
 rtl/fixed_to_fp.sv | 122 ++++++++++++
 tb/tb_fixed_to_fp.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fixed_to_fp_pkg.sv
// Shared single-precision float field constants.
// Reused by the fixed/float converter blocks.
package fixed_to_fp_pkg;

    localparam int EXP_BIAS    = 127;
    localparam int EXP_WIDTH   = 8;
    localparam int MANT_WIDTH  = 23;
    localparam int FLOAT_WIDTH = 32;

    function automatic logic [FLOAT_WIDTH-1:0] fp_pack(
        input logic                  sign,
        input logic [EXP_WIDTH-1:0]  exp,
        input logic [MANT_WIDTH-1:0] mant
    );
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/fixed_to_fp.sv
// Fixed-point (s1.f) to IEEE-754 single conversion.
// Normalises by shifting one bit per cycle.
module fixed_to_fp
    import fixed_to_fp_pkg::*;
#(
    parameter int WORD_LENGTH = 21
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [FLOAT_WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int MSB = WORD_LENGTH - 1;
    localparam int SW  = $clog2(WORD_LENGTH);
    localparam int MSH = MANT_WIDTH - WORD_LENGTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_sign;
    logic [WORD_LENGTH-1:0] r_mag;
    logic [SW-1:0]          r_s;
    logic [FLOAT_WIDTH-1:0] r_out_data;
    logic                   r_out_valid;

    logic [WORD_LENGTH-1:0] w_abs;
    logic                   w_accept;
    logic                   w_zero;
    logic [EXP_WIDTH-1:0]   w_exp;
    logic [MANT_WIDTH-1:0]  w_mant;

    // Two's-complement magnitude; most negative maps to 2^(W-1).
    assign w_abs    = in_data[MSB] ? (-in_data) : in_data;
    assign w_zero   = (w_abs == '0);
    assign in_ready = (r_state == IDLE) && !reset;
    assign w_accept = in_valid && in_ready;

    // Leading one sits at 2^(1-s), so biased exponent is 128-s.
    assign w_exp  = EXP_WIDTH'(EXP_BIAS + 1 - int'(r_s));
    assign w_mant = MANT_WIDTH'(r_mag[MSB-1:0]) << MSH;

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_zero ? DONE : NORM;
                end
            end
            NORM: begin
                if (r_mag[MSB]) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, normalisation shift and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_s         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == DONE);
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sign <= w_zero ? 1'b0 : in_data[MSB];
                        r_mag  <= w_abs;
                        r_s    <= '0;
                        if (w_zero) begin
                            r_out_data <= '0;
                        end
                    end
                end
                NORM: begin
                    if (!r_mag[MSB]) begin
                        r_mag <= r_mag << 1;
                        r_s   <= r_s + 1'b1;
                    end else begin
                        r_out_data <= fp_pack(r_sign, w_exp, w_mant);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_to_fp.sv
// Directed bench for fixed_to_fp at WORD_LENGTH=21.
// Inputs driven and outputs sampled 1ns after the rising edge.
module tb_fixed_to_fp;

    localparam int W = 21;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fixed_to_fp #(.WORD_LENGTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand, measure latency, check result and handshake.
    task automatic convert(input logic [W-1:0] d, input logic [31:0] exp_d,
                           input int exp_lat, input string nm);
        int cyc;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready before accept: got %b want 1", nm, in_ready);
        end
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s out_valid timeout: got %b want 1", nm, out_valid);
        end
        n_tests++;
        if (cyc != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got N+%0d want N+%0d", nm, cyc, exp_lat);
        end
        n_tests++;
        if (out_data !== exp_d) begin
            n_fail++;
            $display("FAIL %s out_data: got %h want %h", nm, out_data, exp_d);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s post-handshake: got valid=%b ready=%b want 0/1",
                     nm, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        step();
        step();
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b valid=%b data=%h want 0/0/0",
                     in_ready, out_valid, out_data);
        end
        reset = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_convert();
        convert(21'h080000, 32'h3F800000, 3,  "plus_one");
        convert(21'h140000, 32'hBFC00000, 3,  "minus_1p5");
        convert(21'h100000, 32'hC0000000, 2,  "minus_two");
        convert(21'h0FFFFF, 32'h3FFFFFF0, 3,  "max_pos");
        convert(21'h000001, 32'h36000000, 22, "one_lsb");
        convert(21'h1FFFFF, 32'hB6000000, 22, "minus_lsb");
        convert(21'h000000, 32'h00000000, 1,  "zero");
        convert(21'h040000, 32'h3F000000, 4,  "plus_half");
    endtask

    task automatic test_backpressure();
        int cyc;
        in_data  = 21'h080000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_wait out_valid: got %b want 1", out_valid);
        end
        in_valid = 1'b1;
        in_data  = 21'h000001;
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 32'h3F800000 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b data=%h ready=%b want 1/3f800000/0",
                         i, out_valid, out_data, in_ready);
            end
        end
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int spurious;
        in_data  = 21'h000001;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_data  = '0;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid in_ready during reset: got %b want 0", in_ready);
        end
        step();
        reset = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid after: got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (out_valid === 1'b1) spurious++;
        end
        n_tests++;
        if (spurious != 0) begin
            n_fail++;
            $display("FAIL rst_mid spurious out_valid: got %0d cycles want 0", spurious);
        end
        convert(21'h140000, 32'hBFC00000, 3, "after_reset");
    endtask

    initial begin
        test_reset();
        test_convert();
        test_backpressure();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
